method_call_sequencer: RTL and testbench
========================================

// Module: method_call_sequencer
// PURPOSE
//  Drives the req/busy/return call handshake of one synthesized method (e.g. Test020 test()).
//  Issues RUNS back-to-back invocations after a settle delay and checks each 1-bit return.
//  Guards every call with a cycle watchdog and reports pass/fail, run and fail counts, and
//  last-call latency. Sits directly upstream of the method block; feeds test_req, consumes
//  test_busy and test_return.
// PARAMETERS
//  RUNS           1       invocations per start (>=1)
//  SETTLE_CYCLES  4       idle cycles after start before first req (>=1)
//  TIMEOUT_CYCLES 100000  max cycles per call, ISSUE to busy falling, before abort
// PORTS
//  clk            in   1   system clock, rising edge
//  reset          in   1   asynchronous, active-high reset
//  start          in   1   level; sampled only in IDLE or FINISH
//  method_req     out  1   to <method>_req
//  method_busy    in   1   from <method>_busy
//  method_return  in   1   from <method>_return; valid when busy falls
//  done           out  1   high in FINISH
//  pass           out  1   valid when done: fail_count==0 and timeout==0
//  timeout        out  1   sticky; watchdog expired in the current sequence
//  run_count      out  16  completed calls, saturates at 16'hFFFF
//  fail_count     out  16  calls whose return!=1, saturates at 16'hFFFF
//  last_latency   out  32  cycles from ISSUE to CHECK for the most recent call
// BEHAVIOUR
//  Reset: every output 0, state IDLE. Asserting reset mid-call drops method_req immediately.
//  All state and outputs are registered. States: IDLE, SETTLE, ISSUE, WAIT_BUSY, WAIT_DONE,
//  CHECK, FINISH.
//  - IDLE: req=0. On start=1, clear counters, timeout, pass and last_latency; go to SETTLE.
//  - SETTLE: count SETTLE_CYCLES cycles, then go to ISSUE.
//  - ISSUE: set req=1, clear cyc=0; go to WAIT_BUSY.
//  - WAIT_BUSY: hold req=1, cyc++. On busy=1, go to WAIT_DONE; req=0 from the next cycle.
//  - WAIT_DONE: req=0, cyc++. On busy=0, sample method_return and go to CHECK.
//  - CHECK: last_latency<=cyc; run_count++; fail_count++ if return!=1.
//    If run_count (new value) == RUNS, go to FINISH; otherwise go to ISSUE (no settle between runs).
//  - Watchdog: in WAIT_BUSY or WAIT_DONE, when cyc reaches TIMEOUT_CYCLES, set timeout=1,
//    req=0, and go to FINISH. The aborted call is not counted.
//  - FINISH: done=1, pass=(fail_count==0 && !timeout). On start=1, clear all and go to SETTLE.
//    Clearing done takes effect the same edge.
//  - start is ignored in SETTLE through CHECK.
//  - Busy already high in ISSUE (a leftover call): WAIT_BUSY accepts it. This is caller error;
//    no extra detection.
//  - Busy rising and the watchdog expiring on the same cycle: timeout wins.
//  - Busy pulse of a single cycle: WAIT_BUSY then WAIT_DONE, CHECK one cycle after busy falls.
//  - The cyc counter is 32 bits. It cannot wrap, because the watchdog fires first.
// TESTING
//  Bench uses a behavioural method stub with programmable busy length L and return value R.
//  1 RUNS=1, L=10, R=1, start at cycle 20 -> req high for 2 cycles; done within 20 cycles
//    after busy falls; pass=1, run_count=1, fail_count=0, last_latency=12.
//  2 RUNS=3, R=1,0,1 -> done=1, pass=0, run_count=3, fail_count=1, timeout=0.
//  3 Stub never raises busy, TIMEOUT_CYCLES=50 -> req drops after 50 cycles in WAIT_BUSY;
//    timeout=1, pass=0, run_count=0.
//  4 Stub holds busy forever after rising, TIMEOUT_CYCLES=50 -> timeout=1, req already 0, done=1.
//  5 Assert reset 3 cycles into WAIT_DONE -> all outputs 0 asynchronously, no clock needed.
//    Then start again -> normal pass.
//  6 start held high through a full run, RUNS=1 -> FINISH reached, then immediate restart.
//    Second run completes with run_count=1, not 2.

Source files
------------

// File: rtl/method_call_sequencer.sv
// Sequencer for one method's req/busy/return handshake: settles, issues RUNS calls back to back,
// checks each return bit, and guards every call with a cycle watchdog.
module method_call_sequencer #(
  parameter int unsigned RUNS           = 1,
  parameter int unsigned SETTLE_CYCLES  = 4,
  parameter int unsigned TIMEOUT_CYCLES = 100000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  output logic        method_req,
  input  logic        method_busy,
  input  logic        method_return,
  output logic        done,
  output logic        pass,
  output logic        timeout,
  output logic [15:0] run_count,
  output logic [15:0] fail_count,
  output logic [31:0] last_latency
);

  localparam int unsigned CW = 32;
  localparam int unsigned NW = 16;

  typedef enum logic [2:0] {
    S_IDLE, S_SETTLE, S_ISSUE, S_WAIT_BUSY, S_WAIT_DONE, S_CHECK, S_FINISH
  } state_e;

  state_e          state_q, state_d;
  logic [CW-1:0]   cyc_q, cyc_d;
  logic            req_q, req_d;
  logic            done_q, done_d;
  logic            pass_q, pass_d;
  logic            timeout_q, timeout_d;
  logic            ret_q, ret_d;
  logic [NW-1:0]   run_q, run_d;
  logic [NW-1:0]   fail_q, fail_d;
  logic [CW-1:0]   lat_q, lat_d;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= S_IDLE;
      cyc_q     <= '0;
      req_q     <= 1'b0;
      done_q    <= 1'b0;
      pass_q    <= 1'b0;
      timeout_q <= 1'b0;
      ret_q     <= 1'b0;
      run_q     <= '0;
      fail_q    <= '0;
      lat_q     <= '0;
    end else begin
      state_q   <= state_d;
      cyc_q     <= cyc_d;
      req_q     <= req_d;
      done_q    <= done_d;
      pass_q    <= pass_d;
      timeout_q <= timeout_d;
      ret_q     <= ret_d;
      run_q     <= run_d;
      fail_q    <= fail_d;
      lat_q     <= lat_d;
    end
  end

  // cyc_q doubles as the settle counter and, from ISSUE on, the cycles elapsed since ISSUE.
  always_comb begin
    state_d   = state_q;
    cyc_d     = cyc_q;
    timeout_d = timeout_q;
    ret_d     = ret_q;
    run_d     = run_q;
    fail_d    = fail_q;
    lat_d     = lat_q;
    req_d     = 1'b0;
    done_d    = 1'b0;
    pass_d    = 1'b0;

    unique case (state_q)
      S_IDLE, S_FINISH: begin
        if (start) begin
          state_d   = S_SETTLE;
          cyc_d     = '0;
          timeout_d = 1'b0;
          run_d     = '0;
          fail_d    = '0;
          lat_d     = '0;
        end
      end
      S_SETTLE: begin
        if (cyc_q >= CW'(SETTLE_CYCLES - 1)) begin
          state_d = S_ISSUE;
          cyc_d   = '0;
        end else begin
          cyc_d = cyc_q + CW'(1);
        end
      end
      S_ISSUE: begin
        cyc_d   = cyc_q + CW'(1);
        state_d = S_WAIT_BUSY;
      end
      S_WAIT_BUSY: begin
        cyc_d = cyc_q + CW'(1);
        if (cyc_q >= CW'(TIMEOUT_CYCLES)) begin
          timeout_d = 1'b1;
          state_d   = S_FINISH;
        end else if (method_busy) begin
          state_d = S_WAIT_DONE;
        end
      end
      S_WAIT_DONE: begin
        cyc_d = cyc_q + CW'(1);
        if (cyc_q >= CW'(TIMEOUT_CYCLES)) begin
          timeout_d = 1'b1;
          state_d   = S_FINISH;
        end else if (!method_busy) begin
          ret_d   = method_return;
          state_d = S_CHECK;
        end
      end
      S_CHECK: begin
        lat_d = cyc_q;
        run_d = (run_q == '1) ? run_q : run_q + NW'(1);
        if (!ret_q) fail_d = (fail_q == '1) ? fail_q : fail_q + NW'(1);
        cyc_d   = '0;
        state_d = (run_d == NW'(RUNS)) ? S_FINISH : S_ISSUE;
      end
      default: state_d = S_IDLE;
    endcase

    // Outputs are registered from the next state so they line up with the state they describe.
    req_d  = (state_d == S_ISSUE) || (state_d == S_WAIT_BUSY);
    done_d = (state_d == S_FINISH);
    pass_d = (state_d == S_FINISH) && (fail_d == '0) && !timeout_d;
  end

  assign method_req   = req_q;
  assign done         = done_q;
  assign pass         = pass_q;
  assign timeout      = timeout_q;
  assign run_count    = run_q;
  assign fail_count   = fail_q;
  assign last_latency = lat_q;

endmodule

// File: tb/tb_method_call_sequencer.sv
// Bench for method_call_sequencer: two instances (RUNS=1 and RUNS=3) each driven by a
// behavioural method stub; expected results are queued at start and compared at done.
module tb_method_call_sequencer;

  localparam int unsigned BUSY_LEN = 10;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  logic        start_a, req_a, busy_a, ret_a, done_a, pass_a, to_a;
  logic [15:0] rc_a, fc_a;
  logic [31:0] lat_a;
  logic        start_b, req_b, busy_b, ret_b, done_b, pass_b, to_b;
  logic [15:0] rc_b, fc_b;
  logic [31:0] lat_b;

  method_call_sequencer #(.RUNS(1), .SETTLE_CYCLES(4), .TIMEOUT_CYCLES(50)) dut_a (
    .clk(clk), .reset(reset), .start(start_a), .method_req(req_a), .method_busy(busy_a),
    .method_return(ret_a), .done(done_a), .pass(pass_a), .timeout(to_a),
    .run_count(rc_a), .fail_count(fc_a), .last_latency(lat_a)
  );

  method_call_sequencer #(.RUNS(3), .SETTLE_CYCLES(4), .TIMEOUT_CYCLES(50)) dut_b (
    .clk(clk), .reset(reset), .start(start_b), .method_req(req_b), .method_busy(busy_b),
    .method_return(ret_b), .done(done_b), .pass(pass_b), .timeout(to_b),
    .run_count(rc_b), .fail_count(fc_b), .last_latency(lat_b)
  );

  // Stub modes: 0 normal busy pulse of BUSY_LEN, 1 never busy, 2 busy stuck high once raised.
  int          mode_a;
  int          cnt_a, cnt_b, calls_b;
  logic [2:0]  ret_pat_b;

  always @(posedge clk or posedge reset) begin
    if (reset) begin
      busy_a <= 1'b0;
      ret_a  <= 1'b0;
      cnt_a  <= 0;
    end else if (busy_a) begin
      if (mode_a != 2) begin
        if (cnt_a <= 1) busy_a <= 1'b0;
        else cnt_a <= cnt_a - 1;
      end
    end else if (req_a && mode_a != 1) begin
      busy_a <= 1'b1;
      cnt_a  <= BUSY_LEN;
      ret_a  <= 1'b1;
    end
  end

  always @(posedge clk or posedge reset) begin
    if (reset) begin
      busy_b  <= 1'b0;
      ret_b   <= 1'b0;
      cnt_b   <= 0;
      calls_b <= 0;
    end else if (busy_b) begin
      if (cnt_b <= 1) busy_b <= 1'b0;
      else cnt_b <= cnt_b - 1;
    end else if (req_b) begin
      busy_b  <= 1'b1;
      cnt_b   <= BUSY_LEN;
      ret_b   <= ret_pat_b[calls_b];
      calls_b <= (calls_b == 2) ? 0 : calls_b + 1;
    end
  end

  typedef struct {
    logic        pass;
    logic        to;
    logic [15:0] rc;
    logic [15:0] fc;
    logic [31:0] lat;
  } exp_t;

  exp_t sb_a[$];
  exp_t sb_b[$];
  int checks   = 0;
  int failures = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  function automatic exp_t mk(input logic p, input logic t, input int rc, input int fc, input int lat);
    exp_t e;
    e.pass = p;
    e.to   = t;
    e.rc   = 16'(rc);
    e.fc   = 16'(fc);
    e.lat  = 32'(lat);
    return e;
  endfunction

  task automatic pulse_start(input bit sel);
    @(negedge clk);
    if (sel) start_b = 1'b1; else start_a = 1'b1;
    @(negedge clk);
    if (sel) start_b = 1'b0; else start_a = 1'b0;
  endtask

  task automatic wait_done(input bit sel, input int budget, output int req_cyc);
    bit seen;
    seen    = 1'b0;
    req_cyc = 0;
    for (int i = 0; i < budget && !seen; i++) begin
      @(negedge clk);
      if (sel ? req_b : req_a) req_cyc++;
      if (sel ? done_b : done_a) seen = 1'b1;
    end
    if (!seen) check_eq("wait_done", 32'd0, 32'd1);
  endtask

  task automatic compare_result(input bit sel, input string tag);
    exp_t e;
    if (sel ? (sb_b.size() == 0) : (sb_a.size() == 0)) begin
      check_eq({tag, "_sb_empty"}, 32'd1, 32'd0);
      return;
    end
    e = sel ? sb_b.pop_front() : sb_a.pop_front();
    check_eq({tag, "_done"},  32'(sel ? done_b : done_a), 32'd1);
    check_eq({tag, "_pass"},  32'(sel ? pass_b : pass_a), 32'(e.pass));
    check_eq({tag, "_to"},    32'(sel ? to_b : to_a), 32'(e.to));
    check_eq({tag, "_runs"},  32'(sel ? rc_b : rc_a), 32'(e.rc));
    check_eq({tag, "_fails"}, 32'(sel ? fc_b : fc_a), 32'(e.fc));
    check_eq({tag, "_lat"},   sel ? lat_b : lat_a, e.lat);
  endtask

  task automatic check_all_zero(input string tag);
    check_eq({tag, "_req"},  32'({req_a, req_b}), 32'd0);
    check_eq({tag, "_done"}, 32'({done_a, done_b}), 32'd0);
    check_eq({tag, "_pass"}, 32'({pass_a, pass_b}), 32'd0);
    check_eq({tag, "_to"},   32'({to_a, to_b}), 32'd0);
    check_eq({tag, "_rc"},   {rc_a, rc_b}, 32'd0);
    check_eq({tag, "_fc"},   {fc_a, fc_b}, 32'd0);
    check_eq({tag, "_lat"},  lat_a | lat_b, 32'd0);
  endtask

  initial begin
    int rq;
    bit seen;
    reset     = 1'b1;
    start_a   = 1'b0;
    start_b   = 1'b0;
    mode_a    = 0;
    ret_pat_b = 3'b111;
    repeat (2) @(negedge clk);
    check_all_zero("reset");
    reset = 1'b0;

    // Single passing call; req spans ISSUE plus the one WAIT_BUSY cycle, latency ISSUE->CHECK is 12.
    repeat (18) @(negedge clk);
    sb_a.push_back(mk(1'b1, 1'b0, 1, 0, 12));
    pulse_start(1'b0);
    wait_done(1'b0, 40, rq);
    check_eq("t1_req_cycles", 32'(rq), 32'd2);
    compare_result(1'b0, "t1");

    // Three calls returning 1,0,1.
    ret_pat_b = 3'b101;
    sb_b.push_back(mk(1'b0, 1'b0, 3, 1, 12));
    pulse_start(1'b1);
    wait_done(1'b1, 100, rq);
    compare_result(1'b1, "t2");

    // Busy never rises: ISSUE plus 50 WAIT_BUSY cycles of req, then abort.
    mode_a = 1;
    sb_a.push_back(mk(1'b0, 1'b1, 0, 0, 0));
    pulse_start(1'b0);
    wait_done(1'b0, 100, rq);
    check_eq("t3_req_cycles", 32'(rq), 32'd51);
    compare_result(1'b0, "t3");

    // Busy stuck high: watchdog fires in WAIT_DONE with req already low.
    mode_a = 2;
    sb_a.push_back(mk(1'b0, 1'b1, 0, 0, 0));
    pulse_start(1'b0);
    wait_done(1'b0, 100, rq);
    check_eq("t4_req", 32'(req_a), 32'd0);
    compare_result(1'b0, "t4");
    mode_a = 0;

    // Reset three cycles into the second call's WAIT_DONE clears everything without a clock edge.
    ret_pat_b = 3'b111;
    pulse_start(1'b1);
    seen = 1'b0;
    for (int i = 0; i < 100 && !seen; i++) begin
      @(negedge clk);
      if (rc_b == 16'd1 && busy_b) seen = 1'b1;
    end
    check_eq("t5_reach_call2", 32'(seen), 32'd1);
    repeat (3) @(negedge clk);
    check_eq("t5_pre_rc", 32'(rc_b), 32'd1);
    check_eq("t5_pre_lat", lat_b, 32'd12);
    #2 reset = 1'b1;
    #1 check_all_zero("t5_async");
    @(negedge clk);
    reset = 1'b0;
    sb_b.push_back(mk(1'b1, 1'b0, 3, 0, 12));
    pulse_start(1'b1);
    wait_done(1'b1, 100, rq);
    compare_result(1'b1, "t5_rerun");

    // start held high: FINISH lasts one cycle, restart clears the counts.
    sb_a.push_back(mk(1'b1, 1'b0, 1, 0, 12));
    sb_a.push_back(mk(1'b1, 1'b0, 1, 0, 12));
    @(negedge clk);
    start_a = 1'b1;
    wait_done(1'b0, 100, rq);
    compare_result(1'b0, "t6_first");
    @(negedge clk);
    check_eq("t6_restart_done", 32'(done_a), 32'd0);
    check_eq("t6_restart_rc", 32'(rc_a), 32'd0);
    start_a = 1'b0;
    wait_done(1'b0, 100, rq);
    compare_result(1'b0, "t6_second");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
